// File: rtl/pong_pkg.sv
// Shared types, screen constants and BCD helper for the pong game sequencer.
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SERVE,
    PLAY,
    MISS,
    OVER
  } state_t;

  typedef logic [3:0] bcdDigit_t;

  localparam int unsigned SERVE_X = 320;
  localparam int unsigned SERVE_Y = 200;
  localparam int unsigned MISS_Y  = 460;

  // Two-digit BCD increment that saturates at 99.
  function automatic logic [7:0] bcdInc(input logic [7:0] val);
    bcdDigit_t tens;
    bcdDigit_t ones;
    tens = val[7:4];
    ones = val[3:0];
    if (val == 8'h99) begin
      return val;
    end
    if (ones == 4'd9) begin
      ones = '0;
      tens = tens + 4'd1;
    end else begin
      ones = ones + 4'd1;
    end
    return {tens, ones};
  endfunction

endpackage

// File: rtl/pong_btn_sync.sv
// Two-flop synchronizer for an asynchronous push button plus a rising-edge pulse.
module pong_btn_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);

  logic meta;
  logic sync;
  logic syncPrev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta     <= 1'b0;
      sync     <= 1'b0;
      syncPrev <= 1'b0;
    end else begin
      meta     <= btn;
      sync     <= meta;
      syncPrev <= sync;
    end
  end

  // Both terms are flop outputs, so the pulse is glitch-free.
  assign rise = sync & ~syncPrev;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: serve/play/miss/game-over flow, lives and BCD score.
module pong_game_ctrl #(
  parameter int unsigned LIVES        = 3,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned MISS_FRAMES  = 90,
  parameter int unsigned MISS_Y       = pong_pkg::MISS_Y,
  parameter int unsigned SERVE_X      = pong_pkg::SERVE_X,
  parameter int unsigned SERVE_Y      = pong_pkg::SERVE_Y
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       paddle_hit,
  input  logic [8:0] ball_y,
  output logic       ball_run,
  output logic       ball_load,
  output logic [9:0] load_x,
  output logic [8:0] load_y,
  output logic       load_dir_x,
  output logic [2:0] lives,
  output logic [7:0] score,
  output logic       flash,
  output logic       game_over
);

  import pong_pkg::*;

  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] MISS_LAST  = 8'(MISS_FRAMES - 1);
  localparam logic [8:0] MISS_LINE  = 9'(MISS_Y);
  localparam logic [2:0] LIVES_INIT = 3'(LIVES);

  state_t     state;
  logic [7:0] frameCnt;
  logic [7:0] frameCntInc;
  logic       startRise;

  pong_btn_sync startSync (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (start_btn),
    .rise  (startRise)
  );

  assign load_x      = 10'(SERVE_X);
  assign load_y      = 9'(SERVE_Y);
  assign frameCntInc = frameCnt + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      frameCnt   <= '0;
      ball_run   <= 1'b0;
      ball_load  <= 1'b0;
      load_dir_x <= 1'b0;
      lives      <= LIVES_INIT;
      score      <= '0;
      flash      <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      ball_load <= 1'b0;
      unique case (state)
        IDLE, OVER: begin
          if (startRise) begin
            state      <= SERVE;
            lives      <= LIVES_INIT;
            score      <= '0;
            ball_load  <= 1'b1;
            load_dir_x <= ~load_dir_x;
            frameCnt   <= '0;
            game_over  <= 1'b0;
          end
        end
        SERVE: begin
          if (frame_tick) begin
            if (frameCnt == SERVE_LAST) begin
              state    <= PLAY;
              ball_run <= 1'b1;
              frameCnt <= '0;
            end else begin
              frameCnt <= frameCntInc;
            end
          end
        end
        PLAY: begin
          // A hit and a miss on the same cycle both take effect.
          if (paddle_hit) begin
            score <= bcdInc(score);
          end
          if (frame_tick && (ball_y >= MISS_LINE)) begin
            state    <= MISS;
            ball_run <= 1'b0;
            frameCnt <= '0;
            flash    <= 1'b0;
            if (lives != '0) begin
              lives <= lives - 3'd1;
            end
          end
        end
        MISS: begin
          if (frame_tick) begin
            if (frameCnt == MISS_LAST) begin
              frameCnt <= '0;
              flash    <= 1'b0;
              if (lives == '0) begin
                state     <= OVER;
                game_over <= 1'b1;
              end else begin
                state      <= SERVE;
                ball_load  <= 1'b1;
                load_dir_x <= ~load_dir_x;
              end
            end else begin
              frameCnt <= frameCntInc;
              flash    <= frameCntInc[3];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl with queue-based expected results.
module tb_pong_game_ctrl;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b1;
  logic       frame_tick = 1'b0;
  logic       start_btn  = 1'b0;
  logic       paddle_hit = 1'b0;
  logic [8:0] ball_y     = 9'd100;

  logic       ball_run;
  logic       ball_load;
  logic [9:0] load_x;
  logic [8:0] load_y;
  logic       load_dir_x;
  logic [2:0] lives;
  logic [7:0] score;
  logic       flash;
  logic       game_over;

  int checks   = 0;
  int failures = 0;

  int   expScore = 0;
  int   expLives = 3;
  logic expDir   = 1'b0;

  logic [7:0] scoreQ[$];
  logic       dirQ[$];

  pong_game_ctrl #(
    .LIVES        (3),
    .SERVE_FRAMES (60),
    .MISS_FRAMES  (90)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .start_btn  (start_btn),
    .paddle_hit (paddle_hit),
    .ball_y     (ball_y),
    .ball_run   (ball_run),
    .ball_load  (ball_load),
    .load_x     (load_x),
    .load_y     (load_y),
    .load_dir_x (load_dir_x),
    .lives      (lives),
    .score      (score),
    .flash      (flash),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] toBcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  // One frame strobe; returns at the falling edge right after it is consumed.
  task automatic frame();
    repeat (2) @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic hit();
    logic [7:0] want;
    paddle_hit = 1'b1;
    expScore = (expScore < 99) ? expScore + 1 : 99;
    scoreQ.push_back(toBcd(expScore));
    @(negedge clk);
    paddle_hit = 1'b0;
    want = scoreQ.pop_front();
    checks++;
    if (score !== want) begin
      failures++;
      $display("FAIL score_inc: score=%h required %h", score, want);
    end
    @(negedge clk);
  endtask

  task automatic do_start();
    bit   seen;
    int   n;
    logic d;
    seen = 1'b0;
    n = 0;
    expDir = ~expDir;
    dirQ.push_back(expDir);
    expLives = 3;
    expScore = 0;
    start_btn = 1'b1;
    while (!seen && n < 5) begin
      @(negedge clk);
      n++;
      if (ball_load === 1'b1) seen = 1'b1;
    end
    d = dirQ.pop_front();
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL start_load: ball_load=%b after %0d cycles, required 1", ball_load, n);
    end else begin
      checks++;
      if (load_dir_x !== d) begin
        failures++;
        $display("FAIL start_dir: load_dir_x=%b required %b", load_dir_x, d);
      end
      checks++;
      if (lives !== 3'(expLives) || score !== toBcd(expScore) || game_over !== 1'b0) begin
        failures++;
        $display("FAIL start_state: lives=%0d score=%h game_over=%b required 3 00 0",
                 lives, score, game_over);
      end
      checks++;
      if (load_x !== 10'd320 || load_y !== 9'd200) begin
        failures++;
        $display("FAIL load_xy: load_x=%0d load_y=%0d required 320 200", load_x, load_y);
      end
      @(negedge clk);
      checks++;
      if (ball_load !== 1'b0) begin
        failures++;
        $display("FAIL start_load_width: ball_load=%b required 0", ball_load);
      end
    end
    start_btn = 1'b0;
  endtask

  task automatic serve_frames();
    for (int k = 1; k <= 60; k++) begin
      frame();
      checks++;
      if (ball_run !== (k == 60)) begin
        failures++;
        $display("FAIL serve_run: frame %0d ball_run=%b required %b", k, ball_run, (k == 60));
      end
    end
  endtask

  task automatic miss_cycle(input bit withHit);
    logic [7:0] want;
    logic       d;
    repeat (2) @(negedge clk);
    ball_y = 9'd460;
    frame_tick = 1'b1;
    paddle_hit = withHit;
    if (withHit) begin
      expScore = (expScore < 99) ? expScore + 1 : 99;
      scoreQ.push_back(toBcd(expScore));
    end
    @(negedge clk);
    frame_tick = 1'b0;
    paddle_hit = 1'b0;
    ball_y = 9'd100;
    if (expLives > 0) expLives--;
    checks++;
    if (ball_run !== 1'b0 || lives !== 3'(expLives) || flash !== 1'b0) begin
      failures++;
      $display("FAIL miss_entry: ball_run=%b lives=%0d flash=%b required 0 %0d 0",
               ball_run, lives, flash, expLives);
    end
    if (withHit) begin
      want = scoreQ.pop_front();
      checks++;
      if (score !== want) begin
        failures++;
        $display("FAIL hit_and_miss: score=%h required %h", score, want);
      end
    end
    for (int k = 1; k <= 89; k++) begin
      frame();
      checks++;
      if (flash !== 1'((k >> 3) & 1) || ball_run !== 1'b0) begin
        failures++;
        $display("FAIL miss_flash: frame %0d flash=%b ball_run=%b required %b 0",
                 k, flash, ball_run, 1'((k >> 3) & 1));
      end
    end
    frame();
    if (expLives == 0) begin
      checks++;
      if (game_over !== 1'b1 || ball_load !== 1'b0 || lives !== 3'd0 || ball_run !== 1'b0) begin
        failures++;
        $display("FAIL game_over: game_over=%b ball_load=%b lives=%0d ball_run=%b required 1 0 0 0",
                 game_over, ball_load, lives, ball_run);
      end
    end else begin
      expDir = ~expDir;
      dirQ.push_back(expDir);
      d = dirQ.pop_front();
      checks++;
      if (ball_load !== 1'b1 || load_dir_x !== d || flash !== 1'b0 || game_over !== 1'b0) begin
        failures++;
        $display("FAIL reserve: ball_load=%b load_dir_x=%b flash=%b game_over=%b required 1 %b 0 0",
                 ball_load, load_dir_x, flash, game_over, d);
      end
      @(negedge clk);
      checks++;
      if (ball_load !== 1'b0) begin
        failures++;
        $display("FAIL reserve_width: ball_load=%b required 0", ball_load);
      end
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ball_run !== 1'b0 || ball_load !== 1'b0 || load_dir_x !== 1'b0 || lives !== 3'd3 ||
        score !== 8'h00 || flash !== 1'b0 || game_over !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: run=%b load=%b dir=%b lives=%0d score=%h flash=%b over=%b required 0 0 0 3 00 0 0",
               ball_run, ball_load, load_dir_x, lives, score, flash, game_over);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_serve();
    do_start();
    serve_frames();
  endtask

  task automatic test_score();
    for (int i = 0; i < 12; i++) hit();
    checks++;
    if (score !== 8'h12) begin
      failures++;
      $display("FAIL score_12: score=%h required 12", score);
    end
    for (int i = 0; i < 100; i++) hit();
    checks++;
    if (score !== 8'h99) begin
      failures++;
      $display("FAIL score_sat: score=%h required 99", score);
    end
  endtask

  task automatic test_miss();
    miss_cycle(1'b0);
    checks++;
    if (lives !== 3'd2 || load_dir_x !== 1'b0) begin
      failures++;
      $display("FAIL miss_result: lives=%0d load_dir_x=%b required 2 0", lives, load_dir_x);
    end
  endtask

  task automatic test_game_over();
    serve_frames();
    miss_cycle(1'b0);
    serve_frames();
    miss_cycle(1'b0);
    frame();
    checks++;
    if (game_over !== 1'b1 || ball_load !== 1'b0 || ball_run !== 1'b0) begin
      failures++;
      $display("FAIL over_hold: game_over=%b ball_load=%b ball_run=%b required 1 0 0",
               game_over, ball_load, ball_run);
    end
    do_start();
    serve_frames();
  endtask

  task automatic test_back_to_back();
    miss_cycle(1'b1);
    serve_frames();
    start_btn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (ball_load !== 1'b0) begin
        failures++;
        $display("FAIL start_in_play: cycle %0d ball_load=%b required 0", i, ball_load);
      end
    end
    start_btn = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (ball_run !== 1'b1 || lives !== 3'(expLives) || score !== toBcd(expScore) || game_over !== 1'b0) begin
      failures++;
      $display("FAIL play_after_start: run=%b lives=%0d score=%h over=%b required 1 %0d %h 0",
               ball_run, lives, score, game_over, expLives, toBcd(expScore));
    end
  endtask

  task automatic test_reset_mid();
    while (expScore < 37) hit();
    checks++;
    if (score !== 8'h37) begin
      failures++;
      $display("FAIL score_37: score=%h required 37", score);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ball_run !== 1'b0 || ball_load !== 1'b0 || load_dir_x !== 1'b0 || lives !== 3'd3 ||
        score !== 8'h00 || flash !== 1'b0 || game_over !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: run=%b load=%b dir=%b lives=%0d score=%h flash=%b over=%b required 0 0 0 3 00 0 0",
               ball_run, ball_load, load_dir_x, lives, score, flash, game_over);
    end
    scoreQ.delete();
    dirQ.delete();
    expDir = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (ball_load !== 1'b0 || ball_run !== 1'b0) begin
        failures++;
        $display("FAIL post_reset: cycle %0d ball_load=%b ball_run=%b required 0 0",
                 i, ball_load, ball_run);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_serve();
    test_score();
    test_miss();
    test_game_over();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Game sequencer for the VGA pong datapath. It owns the play/serve/miss/game-over flow. It gates ball motion, reloads the ball at the serve position, and tracks lives and a 2-digit BCD score. It sits beside the ball/collision logic and is clocked by the same pixel clock. All timing advances on the once-per-frame strobe that also updates the ball position.

Parameters:
LIVES, 3, balls per game (1..7)
SERVE_FRAMES, 60, frames the ball is held at the serve point before release (1..255)
MISS_FRAMES, 90, frames spent in the miss/flash state (1..255)
MISS_Y, 460, ball_y at or above this value at a frame strobe counts as a miss
SERVE_X, 320, ball X load value
SERVE_Y, 200, ball Y load value

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
frame_tick  in  1  one-cycle pulse per video frame (ball update strobe)
start_btn  in  1  raw asynchronous push button, active high
paddle_hit  in  1  one-cycle pulse when the ball bounces off the paddle
ball_y  in  9  current ball Y position
ball_run  out  1  high = ball datapath may move the ball on frame_tick
ball_load  out  1  one-cycle pulse: ball datapath loads load_x/load_y/load_dir_x
load_x  out  10  constant SERVE_X
load_y  out  9  constant SERVE_Y
load_dir_x  out  1  serve X direction; toggles on every serve
lives  out  3  remaining lives
score  out  8  BCD {tens, ones}
flash  out  1  miss indicator for the colour mux
game_over  out  1  high in OVER state

Behaviour:
- Reset (async assert, sync deassert handled by a top-level reset): state=IDLE, ball_run=0, ball_load=0, load_dir_x=0, lives=LIVES, score=0x00, flash=0, game_over=0, frame counter=0, sync flops=0.
- start_btn passes through a 2-flop synchronizer, then a rising-edge detector. start_rise is a 1-cycle pulse, 3 cycles after the button edge at most.
- States: IDLE, SERVE, PLAY, MISS, OVER. All outputs are registered.
- IDLE: on start_rise -> SERVE. Also lives<=LIVES, score<=0, ball_load<=1 for one cycle, load_dir_x toggles, frame counter<=0.
- SERVE: ball_run=0. Each frame_tick increments the frame counter. On the frame_tick where counter==SERVE_FRAMES-1 -> PLAY and counter<=0.
- PLAY: ball_run=1. paddle_hit increments score in BCD: ones 9 -> 0 with tens+1; saturates at 0x99. On frame_tick with ball_y>=MISS_Y -> MISS, lives<=lives-1, counter<=0.
- MISS: ball_run=0. flash=counter[3]. Each frame_tick increments the counter. On the frame_tick where counter==MISS_FRAMES-1: if lives==0 -> OVER, else -> SERVE with ball_load pulse, load_dir_x toggle, counter<=0. flash=0 on exit.
- OVER: game_over=1, ball_run=0. On start_rise, the same actions as IDLE start apply -> SERVE, game_over<=0.
- start_rise is ignored in SERVE, PLAY and MISS.
- paddle_hit and a miss in the same cycle: the score increments and the MISS transition is taken.
- paddle_hit outside PLAY is ignored. frame_tick is ignored in IDLE and OVER.
- lives never underflows; it is only decremented from PLAY with lives>=1.
- ball_load is high exactly one cycle per serve, in the cycle after the transition decision.
- Reset asserted mid-game: immediate return to reset values, no pending ball_load.

Decomposition:
- Shared package pong_pkg: state enum (IDLE, SERVE, PLAY, MISS, OVER), screen constants (SERVE_X, SERVE_Y, MISS_Y), BCD digit type.
- One sub-module: pong_btn_sync, a 2-flop synchronizer plus rising-edge pulse, reused later for other buttons.
- BCD increment is a function in pong_pkg.

Test Plan:
1. Reset, then press start -> within 3 cycles ball_load=1 for exactly 1 cycle, lives=3, score=0x00, load_dir_x=1; ball_run stays 0 for 60 frame_ticks, then goes 1 after the 60th.
2. In PLAY, 12 paddle_hit pulses -> score=0x12; 100 pulses from 0 -> score=0x99 (saturated).
3. In PLAY, drive ball_y=460 on a frame_tick -> MISS, lives=2, ball_run=0, flash toggles every 8 frames. After 90 frames -> SERVE with ball_load pulse and load_dir_x=0.
4. Three misses -> OVER, game_over=1, lives=0. Start press -> SERVE, score=0x00, lives=3, game_over=0.
5. paddle_hit and a miss frame_tick in the same cycle -> score +1 and MISS entered. Start presses during PLAY -> no effect.
6. Assert rst_n low mid-PLAY with score 0x37 -> all outputs take reset values asynchronously, without waiting for a clk edge.
